// File: rtl/head_table_pkg.sv
// ---------------------------------------------------------------------------
// head_table_pkg
// Shared types and constants for the hash-table head-pointer storage.
//   - head_state_e : table controller states (INIT sweep, READY service)
//   - head_entry_t : storage entry layout {val, ptr} for the default pointer
//                    width (parity bit on top when HEAD_TABLE_PARITY_EN)
//   - RD_LATENCY   : lookup request to result latency in cycles
//   - even_parity  : parity helper shared by write and lookup paths
// ---------------------------------------------------------------------------
package head_table_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } head_state_e;

    localparam int RD_LATENCY   = 2;
    localparam int HT_PTR_WIDTH = 10;

    typedef struct packed {
`ifdef HEAD_TABLE_PARITY_EN
        logic                    par;
`endif
        logic                    val;
        logic [HT_PTR_WIDTH-1:0] ptr;
    } head_entry_t;

    // Even parity bit: XOR of all data bits, so data plus parity has an even
    // number of ones. Callers zero-extend narrower data, which leaves the
    // result unchanged.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/head_table_sdp_ram.sv
// ---------------------------------------------------------------------------
// simple_dual_port_ram
// Storage array with one write port and one registered read port. A read and
// a write to the same address on the same edge return the old contents; the
// caller is responsible for forwarding if it needs write-before-read.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (read register)
//   wr_en/addr/data   write port, storage updated at the clock edge
//   rd_en/addr        read request, data appears on rd_data after the edge
//   rd_data           registered read data, held when rd_en is low
// ---------------------------------------------------------------------------
module simple_dual_port_ram #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Storage write port; the array itself has no reset (initialised by sweep).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= rd_data;
        end
    end

endmodule

// File: rtl/head_table.sv
// ---------------------------------------------------------------------------
// head_table
// Per-bucket head-pointer storage of the hash table. Sweeps every bucket to
// "empty" after reset or a clear request, then accepts one write and one
// lookup per cycle. Lookups have a fixed latency of 2 cycles; a write to the
// looked-up bucket in the same cycle is forwarded to the result.
// Optional feature macro: HEAD_TABLE_PARITY_EN (even parity per entry,
// checked on lookup; rd_parity_err_o is tied low when undefined).
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   wr_en_i, wr_addr_i, wr_data_*     bucket write
//   rd_en_i, rd_addr_i                lookup request
//   rd_val_o, rd_data_*, rd_parity_err_o  lookup result (held when idle)
//   clear_i                           soft clear, restarts the sweep
//   init_done_o                       table ready
//   err_o                             sticky: access while not ready
// ---------------------------------------------------------------------------
module head_table
    import head_table_pkg::*;
#(
    parameter int A_WIDTH        = 8,
    parameter int HEAD_PTR_WIDTH = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [A_WIDTH-1:0]        wr_addr_i,
    input  logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr_i,
    input  logic                      wr_data_ptr_val_i,
    input  logic                      wr_en_i,
    input  logic                      rd_en_i,
    input  logic [A_WIDTH-1:0]        rd_addr_i,
    output logic                      rd_val_o,
    output logic [HEAD_PTR_WIDTH-1:0] rd_data_ptr_o,
    output logic                      rd_data_ptr_val_o,
    output logic                      rd_parity_err_o,
    input  logic                      clear_i,
    output logic                      init_done_o,
    output logic                      err_o
);

    localparam int PAYLOAD_WIDTH = HEAD_PTR_WIDTH + 1;
`ifdef HEAD_TABLE_PARITY_EN
    localparam int ENTRY_WIDTH   = PAYLOAD_WIDTH + 1;
`else
    localparam int ENTRY_WIDTH   = PAYLOAD_WIDTH;
`endif
    localparam logic [A_WIDTH-1:0] CNT_LAST = {A_WIDTH{1'b1}};

    head_state_e              state_r;
    head_state_e              state_nxt;
    logic [A_WIDTH-1:0]       cnt_r;
    logic [A_WIDTH-1:0]       cnt_nxt;

    logic                     ready;
    logic                     wr_acc;
    logic                     rd_acc;
    logic [PAYLOAD_WIDTH-1:0] wr_payload;
    logic [ENTRY_WIDTH-1:0]   wr_entry;

    logic                     ram_we;
    logic [A_WIDTH-1:0]       ram_waddr;
    logic [ENTRY_WIDTH-1:0]   ram_wdata;
    logic [ENTRY_WIDTH-1:0]   ram_rdata;

    logic                     s1_valid_r;
    logic                     s1_fwd_r;
    logic [PAYLOAD_WIDTH-1:0] s1_fwd_data_r;
    logic [PAYLOAD_WIDTH-1:0] s1_payload;
    logic                     s1_perr;
    logic                     ram_par_mismatch;

    logic                     err_r;

    assign ready       = (state_r == READY);
    assign wr_acc      = wr_en_i & ready;
    assign rd_acc      = rd_en_i & ready;
    assign wr_payload  = {wr_data_ptr_val_i, wr_data_ptr_i};
    assign init_done_o = ready;
    assign err_o       = err_r;

`ifdef HEAD_TABLE_PARITY_EN
    assign wr_entry         = {even_parity(64'(wr_payload)), wr_payload};
    assign ram_par_mismatch = ram_rdata[ENTRY_WIDTH-1] !=
                              even_parity(64'(ram_rdata[PAYLOAD_WIDTH-1:0]));
`else
    assign wr_entry         = wr_payload;
    assign ram_par_mismatch = 1'b0;
`endif

    simple_dual_port_ram #(
        .DATA_WIDTH (ENTRY_WIDTH),
        .ADDR_WIDTH (A_WIDTH)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_addr_i),
        .rd_data (ram_rdata)
    );

    // Controller state and sweep counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= INIT;
            cnt_r   <= {A_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // Next-state logic and storage write-port steering (sweep vs. user write).
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        ram_we    = 1'b0;
        ram_waddr = wr_addr_i;
        ram_wdata = wr_entry;
        case (state_r)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_r;
                ram_wdata = {ENTRY_WIDTH{1'b0}};
                if (cnt_r == CNT_LAST) begin
                    state_nxt = READY;
                    cnt_nxt   = {A_WIDTH{1'b0}};
                end else begin
                    state_nxt = INIT;
                    cnt_nxt   = cnt_r + 1'b1;
                end
            end
            READY: begin
                ram_we = wr_en_i;
                if (clear_i) begin
                    state_nxt = INIT;
                    cnt_nxt   = {A_WIDTH{1'b0}};
                end else begin
                    state_nxt = READY;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = {A_WIDTH{1'b0}};
            end
        endcase
    end

    // Lookup stage 1: remember whether a same-cycle write must be forwarded,
    // because the storage read on that edge still returns the old entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_r    <= 1'b0;
            s1_fwd_r      <= 1'b0;
            s1_fwd_data_r <= {PAYLOAD_WIDTH{1'b0}};
        end else begin
            s1_valid_r    <= rd_acc;
            s1_fwd_r      <= rd_acc & wr_acc & (wr_addr_i == rd_addr_i);
            s1_fwd_data_r <= wr_payload;
        end
    end

    // Select forwarded or stored data; forwarded data never carries an error.
    always_comb begin
        s1_payload = ram_rdata[PAYLOAD_WIDTH-1:0];
        s1_perr    = 1'b0;
        if (s1_fwd_r) begin
            s1_payload = s1_fwd_data_r;
            s1_perr    = 1'b0;
        end else begin
            s1_payload = ram_rdata[PAYLOAD_WIDTH-1:0];
            s1_perr    = ram_par_mismatch;
        end
    end

    // Lookup stage 2: output register, data held between results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_val_o          <= 1'b0;
            rd_data_ptr_o     <= {HEAD_PTR_WIDTH{1'b0}};
            rd_data_ptr_val_o <= 1'b0;
            rd_parity_err_o   <= 1'b0;
        end else if (s1_valid_r) begin
            rd_val_o          <= 1'b1;
            rd_data_ptr_o     <= s1_payload[HEAD_PTR_WIDTH-1:0];
            rd_data_ptr_val_o <= s1_payload[PAYLOAD_WIDTH-1];
            rd_parity_err_o   <= s1_perr;
        end else begin
            rd_val_o          <= 1'b0;
            rd_data_ptr_o     <= rd_data_ptr_o;
            rd_data_ptr_val_o <= rd_data_ptr_val_o;
            rd_parity_err_o   <= 1'b0;
        end
    end

    // Sticky access-while-not-ready flag; only rst_i clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if ((wr_en_i | rd_en_i) & ~ready) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_head_table.sv
// ---------------------------------------------------------------------------
// tb_head_table
// Directed stimulus against head_table (A_WIDTH=4). Each accepted lookup
// pushes its expected result and due cycle into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever rd_val_o is high.
// ---------------------------------------------------------------------------
module tb_head_table;
    import head_table_pkg::*;

    localparam int AW = 4;
    localparam int PW = 10;

    typedef struct {
        logic          val;
        logic [PW-1:0] ptr;
        logic          perr;
        int            due;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] wr_addr_i = '0;
    logic [PW-1:0] wr_data_ptr_i = '0;
    logic          wr_data_ptr_val_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic          rd_en_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic          rd_val_o;
    logic [PW-1:0] rd_data_ptr_o;
    logic          rd_data_ptr_val_o;
    logic          rd_parity_err_o;
    logic          clear_i = 1'b0;
    logic          init_done_o;
    logic          err_o;

    int            checks = 0;
    int            errors = 0;
    int            cyc_cnt = 0;
    exp_t          sb[$];
    logic [PW:0]   model [0:(2**AW)-1];
    logic          model_perr [0:(2**AW)-1];
    bit            tb_ready = 1'b0;

    head_table #(.A_WIDTH(AW), .HEAD_PTR_WIDTH(PW)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .wr_addr_i         (wr_addr_i),
        .wr_data_ptr_i     (wr_data_ptr_i),
        .wr_data_ptr_val_i (wr_data_ptr_val_i),
        .wr_en_i           (wr_en_i),
        .rd_en_i           (rd_en_i),
        .rd_addr_i         (rd_addr_i),
        .rd_val_o          (rd_val_o),
        .rd_data_ptr_o     (rd_data_ptr_o),
        .rd_data_ptr_val_o (rd_data_ptr_val_o),
        .rd_parity_err_o   (rd_parity_err_o),
        .clear_i           (clear_i),
        .init_done_o       (init_done_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2**AW; i++) begin
            model[i]      = '0;
            model_perr[i] = 1'b0;
        end
    endtask

    // One stimulus cycle, driven just after a falling edge. The model applies
    // the write before the lookup (same-cycle forwarding).
    task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [PW-1:0] wp,
                         input logic wv, input logic rd, input logic [AW-1:0] ra,
                         input logic clr, input logic expect_resp);
        exp_t e;
        wr_en_i = wr; wr_addr_i = wa; wr_data_ptr_i = wp; wr_data_ptr_val_i = wv;
        rd_en_i = rd; rd_addr_i = ra; clear_i = clr;
        if (tb_ready && wr) begin
            model[wa]      = {wv, wp};
            model_perr[wa] = 1'b0;
        end
        if (tb_ready && rd && expect_resp) begin
            e.val  = model[ra][PW];
            e.ptr  = model[ra][PW-1:0];
            e.perr = model_perr[ra];
            e.due  = cyc_cnt + RD_LATENCY;
            sb.push_back(e);
        end
        @(negedge clk_i);
        wr_en_i = 1'b0; rd_en_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    // Count falling-edge samples with init_done_o low until it rises; pokes a
    // write and a lookup into the sweep when poke is set.
    task automatic wait_ready(input string name, input bit poke);
        int low = 0;
        while (!init_done_o && low < 100) begin
            low++;
            if (poke && low == 3) begin
                wr_en_i = 1'b1; wr_addr_i = 4'd1; wr_data_ptr_i = 10'h155;
                wr_data_ptr_val_i = 1'b1; rd_en_i = 1'b1; rd_addr_i = 4'd1;
            end else begin
                wr_en_i = 1'b0; rd_en_i = 1'b0;
            end
            @(negedge clk_i);
        end
        wr_en_i = 1'b0; rd_en_i = 1'b0;
        check(name, 32'(low), 32'd16);
        tb_ready = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        exp_t e;
        if (rd_val_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_val: got ptr=0x%0h val=%0b at cycle %0d, required no result",
                         rd_data_ptr_o, rd_data_ptr_val_o, cyc_cnt);
            end else begin
                e = sb.pop_front();
                if (rd_data_ptr_o !== e.ptr || rd_data_ptr_val_o !== e.val ||
                    rd_parity_err_o !== e.perr || cyc_cnt != e.due) begin
                    errors++;
                    $display("FAIL lookup_result: got ptr=0x%0h val=%0b perr=%0b cyc=%0d, required ptr=0x%0h val=%0b perr=%0b cyc=%0d",
                             rd_data_ptr_o, rd_data_ptr_val_o, rd_parity_err_o, cyc_cnt,
                             e.ptr, e.val, e.perr, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        // Reset state
        idle(3);
        check("rst_rd_val", 32'(rd_val_o), 32'd0);
        check("rst_ptr", 32'(rd_data_ptr_o), 32'd0);
        check("rst_val", 32'(rd_data_ptr_val_o), 32'd0);
        check("rst_perr", 32'(rd_parity_err_o), 32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        wait_ready("init_sweep_cycles", 1'b0);
        check("err_after_init", 32'(err_o), 32'd0);

        // All buckets empty after sweep
        for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'(i), 1'b0, 1'b1);
        idle(3);

        // Write then lookup next cycle
        drive(1'b1, 4'd5, 10'h02A, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 10'd0,   1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        idle(3);

        // Same-cycle forward, then lookup followed by a write, then re-read
        drive(1'b1, 4'd3, 10'h011, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 10'd0,   1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
        drive(1'b1, 4'd3, 10'h222, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 10'd0,   1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
        idle(3);

        // Fill buckets 0..7 then back-to-back lookups
        for (int i = 0; i < 8; i++)
            drive(1'b1, 4'(i), 10'(i * 37 + 1), 1'b1 ^ (i % 3 == 0), 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'(i), 1'b0, 1'b1);
        idle(3);

        // Clear with a lookup in flight; access during sweep sets err_o
        drive(1'b1, 4'd9, 10'h3FF, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
        tb_ready = 1'b0;
        model_clear();
        check("err_before_sweep_access", 32'(err_o), 32'd0);
        check("init_done_dropped", 32'(init_done_o), 32'd0);
        wait_ready("clear_sweep_cycles", 1'b1);
        check("err_after_sweep_access", 32'(err_o), 32'd1);
        drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        idle(3);

`ifdef HEAD_TABLE_PARITY_EN
        // Corrupt stored ptr bit 0 of bucket 2
        dut.u_ram.mem[2][0] = ~dut.u_ram.mem[2][0];
        model[2][0]   = ~model[2][0];
        model_perr[2] = 1'b1;
        drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
        idle(3);
`endif

        // Reset mid-lookup: pipeline flushed, sweep restarts, err_o cleared
        drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        rst_i = 1'b1;
        tb_ready = 1'b0;
        model_clear();
        idle(2);
        check("rst_flush_rd_val", 32'(rd_val_o), 32'd0);
        check("rst_err_cleared", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        wait_ready("reinit_sweep_cycles", 1'b0);
        drive(1'b0, 4'd0, 10'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        idle(4);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
